uart_tx_queue: RTL and testbench

//  Byte FIFO plus issue FSM that sits directly upstream of the UART transmitter.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_tx_queue.sv | 98 +++++++++
 tb/tb_uart_tx_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side queue.
// Used by uart_sync_fifo and uart_tx_queue.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_DONE = 2'd2
  } txq_state_t;

  localparam int TXQ_DEFAULT_DEPTH = 16;

  localparam logic [15:0] TXQ_OVF_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == TXQ_OVF_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with level tracking. It owns the accept/pop rules, so a write into a
// full queue is still taken when a pop happens on the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = TXQ_DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          pop_ready,
  output logic [7:0]    rd_data,
  output logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign pop     = pop_ready && !empty && !flush;
  assign wr_ok   = wr_en && !flush && (!full || pop);
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue plus issue FSM feeding a UART transmitter via tx_start/tx_data/tx_busy.
// Optional dropped-write counter enabled by `UART_TXQ_OVF_CNT_EN.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter  int DEPTH = TXQ_DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic [15:0]   ovf_count,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic          idle
);

  txq_state_t state;
  logic [7:0] rd_data;
  logic       pop;
  logic       pop_ready;

  // A byte already on the line (ours or foreign) blocks the next issue.
  assign pop_ready = (state == S_IDLE) && !tx_busy;

  uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .pop_ready (pop_ready),
    .rd_data   (rd_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          tx_start <= 1'b0;
          if (pop) begin
            tx_data  <= rd_data;
            tx_start <= 1'b1;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          tx_start <= 1'b0;
          if (tx_busy) state <= S_DONE;
        end
        S_DONE: begin
          tx_start <= 1'b0;
          if (!tx_busy) state <= S_IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign idle = empty && (state == S_IDLE) && !tx_busy;

`ifdef UART_TXQ_OVF_CNT_EN
  logic [15:0] ovf_q;
  logic        wr_drop;

  // Flush-time writes are discarded on purpose and are not overflows.
  assign wr_drop = wr_en && !flush && full && !pop;

  always_ff @(posedge clk) begin
    if (rst)          ovf_q <= 16'h0000;
    else if (wr_drop) ovf_q <= sat_inc16(ovf_q);
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a queue-based reference model plus a
// behavioural UART that holds tx_busy for a 10-bit frame at 16 clocks per bit.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FRAME = 160;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic [15:0]   ovf_count;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          idle;

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .ovf_count (ovf_count),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .idle      (idle)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mq[$];
  bit         m_in_flight;
  bit         m_busy_seen;
  logic       m_tx_start;
  logic [7:0] m_tx_data;
  int         m_ovf;

  bit         uart_busy;
  bit         foreign;
  int         uart_cnt;
  int         start_count;
  logic [7:0] last_sent;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit         s_rst;
    bit         s_wr;
    bit         s_fl;
    bit         s_busy;
    bit         s_start;
    bit         was_full;
    bit         popped;
    logic [7:0] s_d;
    logic [7:0] s_txd;
    s_rst   = (rst === 1'b1);
    s_wr    = (wr_en === 1'b1);
    s_fl    = (flush === 1'b1);
    s_busy  = tx_busy;
    s_start = (tx_start === 1'b1);
    s_d     = wr_data;
    s_txd   = tx_data;
    @(posedge clk);
    #1;
    if (s_rst) begin
      mq.delete();
      m_in_flight = 1'b0;
      m_busy_seen = 1'b0;
      m_tx_start  = 1'b0;
      m_tx_data   = 8'h00;
      m_ovf       = 0;
    end else begin
      was_full   = (mq.size() == DEPTH);
      popped     = !m_in_flight && (mq.size() != 0) && !s_busy && !s_fl;
      m_tx_start = popped;
      if (m_in_flight) begin
        if (!m_busy_seen) begin
          if (s_busy) m_busy_seen = 1'b1;
        end else if (!s_busy) begin
          m_in_flight = 1'b0;
        end
      end
      if (popped) begin
        m_tx_data   = mq.pop_front();
        m_in_flight = 1'b1;
        m_busy_seen = 1'b0;
      end
      if (s_fl) mq.delete();
      else if (s_wr) begin
        if (!was_full || popped) mq.push_back(s_d);
        else begin
`ifdef UART_TXQ_OVF_CNT_EN
          if (m_ovf < 65535) m_ovf++;
`endif
        end
      end
    end
    // The UART ignores reset of the queue and always finishes its frame.
    if (s_start) begin
      start_count++;
      last_sent = s_txd;
      uart_busy = 1'b1;
      uart_cnt  = FRAME;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) uart_busy = 1'b0;
    end
    tx_busy = uart_busy || foreign;
    check("level",    32'(level),     32'(mq.size()));
    check("full",     32'(full),      32'(mq.size() == DEPTH));
    check("empty",    32'(empty),     32'(mq.size() == 0));
    check("tx_start", 32'(tx_start),  32'(m_tx_start));
    check("tx_data",  32'(tx_data),   32'(m_tx_data));
    check("ovf",      32'(ovf_count), 32'(m_ovf));
    check("idle",     32'(idle),      32'(mq.size() == 0 && !m_in_flight && !tx_busy));
  endtask

  task automatic set_foreign(input bit f);
    foreign = f;
    tx_busy = uart_busy || foreign;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!(mq.size() == 0 && !m_in_flight && !tx_busy) && n < 20000) begin
      cycle();
      n++;
    end
    check(tag, 32'(idle), 32'd1);
  endtask

  initial begin
    int         s0;
    int         exp_ovf;
    logic [7:0] d;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    foreign = 1'b0; uart_busy = 1'b0; uart_cnt = 0; tx_busy = 1'b0;
    start_count = 0; last_sent = 8'h00;
    mq.delete(); m_in_flight = 1'b0; m_busy_seen = 1'b0;
    m_tx_start = 1'b0; m_tx_data = 8'h00; m_ovf = 0;
    cycle();
    cycle();
    rst = 1'b0;
    check("reset_level", 32'(level),    32'd0);
    check("reset_empty", 32'(empty),    32'd1);
    check("reset_start", 32'(tx_start), 32'd0);
    check("reset_idle",  32'(idle),     32'd1);

    // Single byte into an idle queue: start pulse one cycle after the write edge.
    push(8'hA5);
    cycle();
    check("t1_start", 32'(tx_start), 32'd1);
    check("t1_data",  32'(tx_data),  32'hA5);
    cycle();
    check("t1_pulse_width", 32'(tx_start), 32'd0);
    drain("t1_idle");
    check("t1_sent", 32'(last_sent), 32'hA5);

    // Burst of 16 while a foreign frame holds the line, so the queue fills.
    set_foreign(1'b1);
    cycle();
    s0 = start_count;
    for (int i = 1; i <= 16; i++) push(8'(i));
    check("t2_full",  32'(full),  32'd1);
    check("t2_level", 32'(level), 32'd16);

    // Full queue, write coincides with the pop that follows the line freeing up.
    wr_en = 1'b1; wr_data = 8'hEE;
    set_foreign(1'b0);
    cycle();
    wr_en = 1'b0;
    check("t3_level", 32'(level),    32'd16);
    check("t3_start", 32'(tx_start), 32'd1);
    check("t3_data",  32'(tx_data),  32'h01);

    // Full queue with a byte in flight: three writes are dropped.
    for (int i = 0; i < 3; i++) push(8'($urandom));
`ifdef UART_TXQ_OVF_CNT_EN
    exp_ovf = 3;
`else
    exp_ovf = 0;
`endif
    check("t4_ovf",   32'(ovf_count), 32'(exp_ovf));
    check("t4_level", 32'(level),     32'd16);
    drain("t2_idle");
    check("t2_starts", 32'(start_count - s0), 32'd17);
    check("t3_last",   32'(last_sent),        32'hEE);

    // Flush with five queued and one in flight.
    for (int i = 0; i < 6; i++) push(8'($urandom));
    check("t5_level_pre", 32'(level), 32'd5);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("t5_level_post", 32'(level), 32'd0);
    s0 = start_count;
    drain("t5_idle");
    check("t5_no_start", 32'(start_count - s0), 32'd0);

    // Reset while the FSM waits for tx_busy to fall with four queued.
    for (int i = 0; i < 5; i++) push(8'($urandom));
    cycle();
    cycle();
    check("t6_level_pre", 32'(level), 32'd4);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_level", 32'(level),    32'd0);
    check("t6_start", 32'(tx_start), 32'd0);
    check("t6_busy",  32'(tx_busy),  32'd1);
    push(8'h3C);
    for (int i = 0; i < 10; i++) cycle();
    check("t6_hold", 32'(level), 32'd1);
    drain("t6_idle");
    check("t6_sent", 32'(last_sent), 32'h3C);

    // Randomised traffic: bursty writes, occasional flush, foreign frames, rare reset.
    for (int i = 0; i < 4000; i++) begin
      d       = 8'($urandom);
      wr_en   = ($urandom_range(0, 11) == 0);
      wr_data = d;
      flush   = ($urandom_range(0, 399) == 0);
      rst     = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 299) == 0) set_foreign(!foreign);
      cycle();
    end
    wr_en = 1'b0; flush = 1'b0; rst = 1'b0;
    set_foreign(1'b0);
    drain("rand_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
